// File: rtl/expr_string_gen_pkg.sv
// Shared constants and types for the arithmetic-expression frame generator.
// Holds the ASCII symbol set, the FSM enums and the digit mapping helper.
package expr_pkg;

    localparam logic [7:0]  CH_0       = 8'h30;
    localparam logic [7:0]  CH_LPAR    = 8'h28;
    localparam logic [7:0]  CH_RPAR    = 8'h29;
    localparam logic [7:0]  CH_PLUS    = 8'h2B;
    localparam logic [7:0]  CH_STAR    = 8'h2A;
    localparam logic [15:0] LFSR_RESET = 16'hACE1;

    typedef enum logic [1:0] {OPND, POST_NUM, POST_CLS} phase_t;
    typedef enum logic {IDLE, GEN} state_t;

    // Folds a random nibble onto '0'..'9'.
    function automatic logic [7:0] digit_char(input logic [3:0] v);
        logic [3:0] d;
        d = (v >= 4'd10) ? (v - 4'd10) : v;
        return CH_0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/expr_string_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
// A zero seed is replaced by the reset pattern so the register never locks up.
module expr_lfsr16
    import expr_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [15:0] i_seed,
    output logic [8:0]  o_tap
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign o_tap = r_lfsr[8:0];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_lfsr <= LFSR_RESET;
        end else if (i_load) begin
            r_lfsr <= (i_seed == 16'h0000) ? LFSR_RESET : i_seed;
        end else if (i_step) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

endmodule

// File: rtl/expr_string_gen.sv
// Emits one random, syntactically legal arithmetic expression per frame over valid/ready.
// Symbol choice is a pure function of registered state, so outputs have no input-to-output path.
module expr_string_gen
    import expr_pkg::*;
#(
    parameter int MAX_LEN   = 32,
    parameter int MAX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic        inject_err,
    output logic [7:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int WW = ((CW > DW) ? CW : DW) + 2;
    localparam logic [CW-1:0] LEN_C  = CW'(MAX_LEN);
    localparam logic [WW-1:0] MAXD_X = WW'(MAX_DEPTH);

    state_t        r_state, w_state_n;
    phase_t        r_phase, w_phase_n, w_nphase;
    logic [CW-1:0] r_cnt, w_cnt_n, w_rem;
    logic [DW-1:0] r_depth, w_depth_n;
    logic          r_err, w_err_n;
    logic          r_done, w_done_n;

    logic [8:0]    w_tap;
    logic [WW-1:0] w_rem_x, w_dep_x;
    logic [7:0]    w_sym;
    logic          w_open, w_close, w_is_op, w_zero_after, w_last;
    logic          w_start, w_hs;

    assign w_start = (r_state == IDLE) && start;
    assign w_hs    = (r_state == GEN) && out_ready;
    assign w_rem   = LEN_C - r_cnt;
    assign w_rem_x = WW'(w_rem);
    assign w_dep_x = WW'(r_depth);

    expr_lfsr16 u_lfsr (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_load (w_start),
        .i_step (w_hs),
        .i_seed (seed),
        .o_tap  (w_tap)
    );

    // Every branch keeps enough slots to finish the current term and close all open parens.
    always_comb begin
        w_sym    = digit_char(w_tap[7:4]);
        w_nphase = POST_NUM;
        w_open   = 1'b0;
        w_close  = 1'b0;
        w_is_op  = 1'b0;
        if (r_phase == OPND) begin
            if (w_tap[0] && (w_dep_x < MAXD_X) && (w_rem_x >= w_dep_x + WW'(3))) begin
                w_sym    = CH_LPAR;
                w_nphase = OPND;
                w_open   = 1'b1;
            end
        end else if (w_rem_x == w_dep_x) begin
            w_sym    = CH_RPAR;
            w_nphase = POST_CLS;
            w_close  = 1'b1;
        end else if ((r_phase == POST_NUM) && (w_tap[2:1] == 2'b01) &&
                     (w_rem_x >= w_dep_x + WW'(1))) begin
            w_sym    = digit_char(w_tap[7:4]);
            w_nphase = POST_NUM;
        end else if ((w_tap[2:1] == 2'b10) && (r_depth != '0)) begin
            w_sym    = CH_RPAR;
            w_nphase = POST_CLS;
            w_close  = 1'b1;
        end else if (w_rem_x >= w_dep_x + WW'(2)) begin
            w_sym    = w_tap[8] ? CH_STAR : CH_PLUS;
            w_nphase = OPND;
            w_is_op  = 1'b1;
        end else begin
            w_sym    = CH_RPAR;
            w_nphase = POST_CLS;
            w_close  = 1'b1;
        end
    end

    // A term closing at depth 0 with two or fewer slots left must end the frame:
    // continuing would need an operator plus a whole operand.
    assign w_zero_after = w_close ? (r_depth == DW'(1)) : (r_depth == '0);
    assign w_last       = !w_open && !w_is_op && w_zero_after &&
                          ((w_rem_x <= WW'(2)) || w_tap[3]);

    always_comb begin
        w_state_n = r_state;
        w_phase_n = r_phase;
        w_cnt_n   = r_cnt;
        w_depth_n = r_depth;
        w_err_n   = r_err;
        w_done_n  = 1'b0;
        if (w_start) begin
            w_state_n = GEN;
            w_phase_n = OPND;
            w_cnt_n   = '0;
            w_depth_n = '0;
            w_err_n   = inject_err;
        end else if (w_hs) begin
            w_cnt_n   = r_cnt + CW'(1);
            w_phase_n = w_nphase;
            if (w_open) begin
                w_depth_n = r_depth + DW'(1);
            end else if (w_close) begin
                w_depth_n = r_depth - DW'(1);
            end
            if (w_last) begin
                w_state_n = IDLE;
                w_done_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_phase <= OPND;
            r_cnt   <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_phase <= w_phase_n;
            r_cnt   <= w_cnt_n;
            r_depth <= w_depth_n;
            r_err   <= w_err_n;
            r_done  <= w_done_n;
        end
    end

    assign busy      = (r_state == GEN);
    assign out_valid = busy;
    assign out_last  = busy && w_last;
    assign out_char  = !busy ? 8'h00 : ((r_err && w_last) ? CH_PLUS : w_sym);
    assign done      = r_done;

endmodule

// File: tb/tb_expr_string_gen.sv
// Bench for expr_string_gen: single-char table on a MAX_LEN=1 instance, hand-derived
// frames, backpressure/reset sequences and a grammar checker over many random frames.
module tb_expr_string_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n;
    logic        start, inject_err, out_ready;
    logic [15:0] seed;
    logic [7:0]  out_char;
    logic        out_valid, out_last, busy, done;

    logic        start1, inj1, rdy1;
    logic [15:0] seed1;
    logic [7:0]  c1;
    logic        valid1, last1, busy1, done1;

    expr_string_gen #(.MAX_LEN(32), .MAX_DEPTH(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .seed(seed), .inject_err(inject_err),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    expr_string_gen #(.MAX_LEN(1), .MAX_DEPTH(4)) dut1 (
        .clk(clk), .clr_n(clr_n), .start(start1), .seed(seed1), .inject_err(inj1),
        .out_char(c1), .out_valid(valid1), .out_ready(rdy1),
        .out_last(last1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] frame_buf [64];
    logic [7:0] ref_buf   [64];
    int         frame_len, ref_len;
    int         g_state, g_dep, g_max;
    bit         g_bad;

    typedef struct {
        logic [15:0] seed;
        logic        inj;
        logic [7:0]  exp_char;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent recogniser: 0 = expect operand, 1 = inside number, 2 = after ')'.
    function automatic void feed(input logic [7:0] c);
        bit is_dig;
        is_dig = (c >= 8'h30) && (c <= 8'h39);
        case (g_state)
            0: if (is_dig) g_state = 1;
               else if (c == 8'h28) begin g_dep++; if (g_dep > g_max) g_max = g_dep; end
               else g_bad = 1;
            1: if (is_dig) g_state = 1;
               else if (c == 8'h2B || c == 8'h2A) g_state = 0;
               else if (c == 8'h29 && g_dep > 0) begin g_dep--; g_state = 2; end
               else g_bad = 1;
            default: if (c == 8'h2B || c == 8'h2A) g_state = 0;
               else if (c == 8'h29 && g_dep > 0) g_dep--;
               else g_bad = 1;
        endcase
    endfunction

    function automatic bit frame_legal();
        return !g_bad && (g_state != 0) && (g_dep == 0);
    endfunction

    // mode 0: always ready; 1: random ready; 2: 5-cycle stall at char 2 with an ignored start.
    task automatic collect(input logic [15:0] s, input logic inj, input int mode);
        int         cyc;
        bit         fin, stalled;
        logic [7:0] hold_c;
        logic       hold_l;
        frame_len = 0; g_state = 0; g_dep = 0; g_max = 0; g_bad = 0;
        seed = s; inject_err = inj; start = 1'b1;
        tick();
        start = 1'b0; inject_err = 1'b0;
        cyc = 0; fin = 0; stalled = 0;
        while (!fin && cyc < 2000) begin
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2 && frame_len == 2 && !stalled && out_valid) begin
                stalled = 1; hold_c = out_char; hold_l = out_last; out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    if (k == 2) begin seed = 16'h1234; start = 1'b1; end
                    tick();
                    start = 1'b0;
                    check("stall_char", out_char, hold_c);
                    check("stall_last", out_last, hold_l);
                    check("stall_busy", busy, 1);
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                feed(out_char);
                if (frame_len < 64) frame_buf[frame_len] = out_char;
                frame_len++;
                if (out_last) fin = 1;
            end
            tick();
            cyc++;
        end
        check("frame_terminated", fin, 1);
        check("done_pulse", done, 1);
        check("busy_after_last", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
    endtask

    task automatic save_ref();
        ref_len = frame_len;
        for (int i = 0; i < 64; i++) ref_buf[i] = frame_buf[i];
    endtask

    task automatic compare_ref(input string nm, input bit last_is_plus);
        int m;
        m = 0;
        check({nm, "_len"}, frame_len, ref_len);
        for (int i = 0; i < ref_len && i < 64; i++) begin
            if (last_is_plus && i == ref_len - 1) begin
                if (frame_buf[i] !== 8'h2B) m++;
            end else if (frame_buf[i] !== ref_buf[i]) m++;
        end
        check({nm, "_chars"}, m, 0);
    endtask

    initial begin
        vec_t       vecs [7];
        logic [7:0] pfx  [6];

        vecs[0] = '{16'h1234, 1'b0, 8'h33};
        vecs[1] = '{16'h0000, 1'b0, 8'h34};
        vecs[2] = '{16'hACE1, 1'b0, 8'h34};
        vecs[3] = '{16'h00F0, 1'b0, 8'h35};
        vecs[4] = '{16'hFFA5, 1'b0, 8'h30};
        vecs[5] = '{16'h0090, 1'b0, 8'h39};
        vecs[6] = '{16'h1234, 1'b1, 8'h2B};
        pfx = '{8'h28, 8'h37, 8'h2A, 8'h39, 8'h2B, 8'h28};

        clr_n = 1'b0; start = 0; seed = 0; inject_err = 0; out_ready = 0;
        start1 = 0; seed1 = 0; inj1 = 0; rdy1 = 1;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_char", out_char, 8'h00);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        clr_n = 1'b1;
        tick();

        // Single-character frames: the seed itself is the first random word.
        foreach (vecs[i]) begin
            seed1 = vecs[i].seed; inj1 = vecs[i].inj; start1 = 1'b1;
            tick();
            start1 = 1'b0; inj1 = 1'b0;
            check("len1_valid", valid1, 1);
            check("len1_char", c1, vecs[i].exp_char);
            check("len1_last", last1, 1);
            g_state = 0; g_dep = 0; g_max = 0; g_bad = 0;
            feed(c1);
            check("len1_legal", frame_legal(), vecs[i].inj ? 0 : 1);
            tick();
            check("len1_done", done1, 1);
            check("len1_idle", busy1, 0);
            tick();
            check("len1_done_clear", done1, 0);
        end

        collect(16'h1234, 1'b0, 0);
        check("s1234_len", frame_len, 2);
        check("s1234_c0", frame_buf[0], 8'h33);
        check("s1234_c1", frame_buf[1], 8'h31);

        collect(16'h0000, 1'b0, 0);
        save_ref();
        check("s0_legal", frame_legal(), 1);
        for (int i = 0; i < 6; i++) check("s0_prefix", frame_buf[i], pfx[i]);

        collect(16'hACE1, 1'b0, 0);
        compare_ref("seed_zero_alias", 0);
        collect(16'hACE1, 1'b0, 1);
        compare_ref("random_ready", 0);
        collect(16'hACE1, 1'b0, 2);
        compare_ref("stall_and_start", 0);
        collect(16'hACE1, 1'b1, 0);
        compare_ref("inject", 1);
        check("inject_illegal", frame_legal(), 0);

        // Asynchronous clear in the middle of a frame.
        seed = 16'hACE1; start = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();
        #2 clr_n = 1'b0;
        #1;
        check("clr_valid", out_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_last", out_last, 0);
        tick();
        check("clr_no_done", done, 0);
        clr_n = 1'b1;
        tick();
        check("clr_no_done2", done, 0);
        check("clr_idle", busy, 0);
        collect(16'hACE1, 1'b0, 0);
        compare_ref("after_clr", 0);

        for (int n = 0; n < 1000; n++) begin
            collect(16'($urandom), 1'b0, 1);
            check("rand_len", (frame_len >= 1 && frame_len <= 32), 1);
            check("rand_legal", frame_legal(), 1);
            check("rand_depth", g_max <= 4, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
